// File: rtl/sr_excite_driver.sv
// sr_excite_driver: drives S/R of an SR flip-flop toward a requested bit, with settle, feedback check and bounded retry.
module sr_excite_driver #(
  parameter int PULSE_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_data,
  output logic             req_ready,
  input  logic             q_fb,
  input  logic             qb_fb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, SETTLE = 2'd2, CHECK = 2'd3;
  localparam int TMAX = PULSE_CYCLES > SETTLE_CYCLES ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int AW = $clog2(MAX_RETRY + 2);
  logic [1:0] state;
  logic tgt;
  logic [TW-1:0] tmr;
  logic [AW-1:0] att;
  logic fb_valid, acc_match, chk_match;
  assign fb_valid  = q_fb ^ qb_fb;
  assign acc_match = fb_valid & (q_fb == req_data);
  assign chk_match = fb_valid & (q_fb == tgt);
  assign busy      = state != IDLE;
  assign req_ready = (state == IDLE) & ~rst;
  // S/R come from the target alone, so s and r are always complementary while driving
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= 1'b0;
      r         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      att       <= '0;
      tmr       <= '0;
      tgt       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          tgt <= req_data;
          att <= '0;
          if (acc_match) state <= CHECK;
          else begin
            state <= DRIVE;
            s     <= req_data;
            r     <= ~req_data;
            tmr   <= TW'(PULSE_CYCLES - 1);
          end
        end
        DRIVE: if (tmr == '0) begin
          state <= SETTLE;
          s     <= 1'b0;
          r     <= 1'b0;
          tmr   <= TW'(SETTLE_CYCLES - 1);
        end else tmr <= tmr - 1'b1;
        SETTLE: if (tmr == '0) state <= CHECK;
          else tmr <= tmr - 1'b1;
        CHECK: if (chk_match) begin
          done  <= 1'b1;
          state <= IDLE;
        end else if (att != AW'(MAX_RETRY)) begin
          att   <= att + 1'b1;
          state <= DRIVE;
          s     <= tgt;
          r     <= ~tgt;
          tmr   <= TW'(PULSE_CYCLES - 1);
        end else begin
          err   <= 1'b1;
          state <= IDLE;
          if (~&err_count) err_count <= err_count + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sr_excite_driver.sv
// tb_sr_excite_driver: directed table, reset corners and random requests against an SR flip-flop load and outcome model.
module tb_sr_excite_driver;
  localparam int P = 1, S = 2, MR = 1;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_data = 1'b0;
  logic req_ready, s, r, busy, done, err;
  logic [7:0] err_count;
  logic q = 1'b0, qb = 1'b1, ld = 1'b0, ld_q = 1'b0, ld_qb = 1'b1, stuck = 1'b0;
  logic q_fb, qb_fb;
  int n_cmp = 0, n_bad = 0, ecnt = 0;
  assign q_fb  = stuck ? 1'b0 : q;
  assign qb_fb = stuck ? 1'b1 : qb;
  sr_excite_driver #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S), .MAX_RETRY(MR), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .q_fb(q_fb), .qb_fb(qb_fb), .s(s), .r(r), .busy(busy), .done(done), .err(err),
    .err_count(err_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ld) begin
      q  <= ld_q;
      qb <= ld_qb;
    end else if (s & ~r) begin
      q  <= 1'b1;
      qb <= 1'b0;
    end else if (r & ~s) begin
      q  <= 1'b0;
      qb <= 1'b1;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic preload(input logic a, input logic b, input logic stk);
    stuck = stk;
    ld = 1'b1;
    ld_q = a;
    ld_qb = b;
    step();
    ld = 1'b0;
  endtask
  // One request from acceptance to its done/err cycle; expectations come from the outcome model
  task automatic run_req(input logic tgt, output int end_c, output logic dn, output logic [31:0] mask);
    logic fq, fqb, m0, exp_done, both, wrong, got_err;
    int n_att, exp_end;
    logic [31:0] exp_mask, exp_busy, bmask;
    fq = stuck ? 1'b0 : q;
    fqb = stuck ? 1'b1 : qb;
    m0 = (fq != fqb) && (fq == tgt);
    n_att = m0 ? 0 : (stuck ? MR + 1 : 1);
    exp_end = m0 ? 2 : n_att * (P + S + 1) + 1;
    exp_done = m0 || !stuck;
    exp_mask = '0;
    for (int a = 0; a < n_att; a++)
      for (int j = 0; j < P; j++) exp_mask[1 + a * (P + S + 1) + j] = 1'b1;
    exp_busy = '0;
    for (int k = 1; k < exp_end; k++) exp_busy[k] = 1'b1;
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_data = tgt;
    step();
    req_valid = 1'b0;
    req_data = 1'($urandom);
    end_c = 0;
    dn = 1'b0;
    got_err = 1'b0;
    mask = '0;
    bmask = '0;
    both = 1'b0;
    wrong = 1'b0;
    for (int k = 1; k < 30; k++) begin
      mask[k] = s | r;
      bmask[k] = busy;
      both = both | (s & r);
      wrong = wrong | (tgt ? r : s);
      if (done | err) begin
        end_c = k;
        dn = done;
        got_err = err;
        break;
      end
      step();
    end
    if (!exp_done) ecnt = ecnt < 255 ? ecnt + 1 : 255;
    chk("end_cycle", 32'(end_c), 32'(exp_end));
    chk("done_flag", 32'(dn), 32'(exp_done));
    chk("err_flag", 32'(got_err), 32'(!exp_done));
    chk("pulse_mask", mask, exp_mask);
    chk("busy_mask", bmask, exp_busy);
    chk("s_and_r", 32'(both), 32'd0);
    chk("drive_polarity", 32'(wrong), 32'd0);
    chk("err_count", 32'(err_count), 32'(ecnt));
    if (exp_done && !stuck) chk("load_q", 32'(q), 32'(tgt));
  endtask
  typedef struct {
    logic a, b, stk, tgt;
    int end_c;
    logic dn;
    logic [31:0] mask;
  } vec_t;
  vec_t tbl[6];
  int end_c, gap;
  logic dn, tg, seen;
  logic [31:0] mask;
  int rst_at[2];
  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b1, 32'h0000_0002};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 32'h0000_0000};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 9, 1'b0, 32'h0000_0022};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b1, 32'h0000_0002};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b1, 32'h0000_0002};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b1, 32'h0000_0000};
    rst_at[0] = 3;
    rst_at[1] = 1;
    step();
    chk("reset_outputs", {26'd0, s, r, busy, done, err, req_ready}, 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    step();
    chk("reset_outputs_2", {26'd0, s, r, busy, done, err, req_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_reset", {28'd0, req_ready, busy, done, err}, 32'h8);
    foreach (tbl[i]) begin
      preload(tbl[i].a, tbl[i].b, tbl[i].stk);
      run_req(tbl[i].tgt, end_c, dn, mask);
      chk($sformatf("tbl%0d_end", i), 32'(end_c), 32'(tbl[i].end_c));
      chk($sformatf("tbl%0d_done", i), 32'(dn), 32'(tbl[i].dn));
      chk($sformatf("tbl%0d_mask", i), mask, tbl[i].mask);
      step();
      chk($sformatf("tbl%0d_pulse_width", i), {30'd0, done, err}, 32'd0);
    end
    chk("err_count_after_table", 32'(err_count), 32'd1);
    foreach (rst_at[i]) begin
      preload(1'b0, 1'b1, 1'b1);
      req_valid = 1'b1;
      req_data = 1'b1;
      step();
      req_valid = 1'b0;
      for (int k = 1; k < rst_at[i]; k++) step();
      rst = 1'b1;
      step();
      ecnt = 0;
      chk($sformatf("midrst%0d_outputs", i), {27'd0, s, r, busy, done, err}, 32'd0);
      chk($sformatf("midrst%0d_err_count", i), 32'(err_count), 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        step();
        seen = seen | done | err | busy;
      end
      chk($sformatf("midrst%0d_quiet", i), 32'(seen), 32'd0);
    end
    for (int i = 0; i < 200; i++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        stuck = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) begin
          ld = 1'b1;
          ld_q = 1'($urandom);
          ld_qb = 1'($urandom);
        end
        step();
        ld = 1'b0;
        for (int g = 1; g < gap; g++) step();
      end
      tg = 1'($urandom_range(0, 1));
      run_req(tg, end_c, dn, mask);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
